// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: control bundle, result-source and ALU encodings.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    // Writeback result selection
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Decoded control bundle travelling down the pipeline
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_ctrl;
        logic       alu_src;
    } ctrl_t;

    // All-zero bundle: no register write, no store, no branch, no jump
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection and redirect-driven flush for the ID stage.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic             valid_d,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic             valid_e,
    input  logic [1:0]       result_src_e,
    input  logic [REG_W-1:0] rd_e,
    input  logic             pc_src_e,
    output logic             lw_stall,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d
);

    // A load in EX whose destination is read by the ID instruction must hold ID one cycle;
    // a redirect from EX discards the ID instruction anyway, so it suppresses the stall.
    always_comb begin
        lw_stall = valid_e && (result_src_e == RES_MEM) && (rd_e != '0) && valid_d
                   && ((rs1_d == rd_e) || (rs2_d == rd_e));
        stall_f  = lw_stall && !pc_src_e;
        stall_d  = lw_stall && !pc_src_e;
        flush_d  = pc_src_e;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbles, redirect flushes and saturating perf counters.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [XLEN-1:0]  pc_plus4_d,
    input  logic [XLEN-1:0]  rd1_d,
    input  logic [XLEN-1:0]  rd2_d,
    input  logic [XLEN-1:0]  imm_ext_d,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rd_d,
    input  ctrl_t            ctrl_d,
    input  logic             pc_src_e,
    output logic             valid_e,
    output logic [XLEN-1:0]  pc_e,
    output logic [XLEN-1:0]  pc_plus4_e,
    output logic [XLEN-1:0]  rd1_e,
    output logic [XLEN-1:0]  rd2_e,
    output logic [XLEN-1:0]  imm_ext_e,
    output logic [REG_W-1:0] rs1_e,
    output logic [REG_W-1:0] rs2_e,
    output logic [REG_W-1:0] rd_e,
    output ctrl_t            ctrl_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic [31:0]      bubble_count,
    output logic [31:0]      flush_count
);

    logic lw_stall;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    hazard_detect u_hazard (
        .valid_d      (valid_d),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .valid_e      (valid_e),
        .result_src_e (ctrl_e.result_src),
        .rd_e         (rd_e),
        .pc_src_e     (pc_src_e),
        .lw_stall     (lw_stall),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d)
    );

    // Pipeline register: reset, redirect and load-use all load an all-zero bubble; else capture ID.
    always_ff @(posedge clk) begin
        if (reset || pc_src_e || lw_stall) begin
            valid_e    <= 1'b0;
            ctrl_e     <= CTRL_NOP;
            pc_e       <= '0;
            pc_plus4_e <= '0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_ext_e  <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
        end else begin
            valid_e    <= valid_d;
            ctrl_e     <= valid_d ? ctrl_d : CTRL_NOP;
            pc_e       <= pc_d;
            pc_plus4_e <= pc_plus4_d;
            rd1_e      <= rd1_d;
            rd2_e      <= rd2_d;
            imm_ext_e  <= imm_ext_d;
            rs1_e      <= rs1_d;
            rs2_e      <= rs2_d;
            rd_e       <= rd_d;
        end
    end

    // Perf counters: a redirect is counted as a flush even when a load-use hazard coincides.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else if (pc_src_e) begin
            flush_count  <= sat_inc(flush_count);
        end else if (lw_stall) begin
            bubble_count <= sat_inc(bubble_count);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model pushes expected ID/EX state each cycle.
module tb_id_ex_stage;
    import riscv_pkg::*;

    typedef struct {
        logic        valid;
        ctrl_t       ctrl;
        logic [31:0] pc, pc4, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] bc, fc;
    } exp_t;

    localparam ctrl_t CT_ADD = '{reg_write: 1'b1, result_src: RES_ALU, mem_write: 1'b0,
                                 jump: 1'b0, branch: 1'b0, alu_ctrl: ALU_ADD, alu_src: 1'b0};
    localparam ctrl_t CT_LW  = '{reg_write: 1'b1, result_src: RES_MEM, mem_write: 1'b0,
                                 jump: 1'b0, branch: 1'b0, alu_ctrl: ALU_ADD, alu_src: 1'b1};

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_d;
    logic [31:0] pc_d, pc_plus4_d, rd1_d, rd2_d, imm_ext_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    ctrl_t       ctrl_d;
    logic        pc_src_e;
    logic        valid_e;
    logic [31:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_ext_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    ctrl_t       ctrl_e;
    logic        stall_f, stall_d, flush_d;
    logic [31:0] bubble_count, flush_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t m;
    bit   m_known = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .valid_d(valid_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rd_d(rd_d), .ctrl_d(ctrl_d), .pc_src_e(pc_src_e), .valid_e(valid_e), .pc_e(pc_e),
        .pc_plus4_e(pc_plus4_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .ctrl_e(ctrl_e), .stall_f(stall_f),
        .stall_d(stall_d), .flush_d(flush_d), .bubble_count(bubble_count),
        .flush_count(flush_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : v + 1;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d, input ctrl_t c,
                         input logic ps);
        valid_d = v; pc_d = pc; pc_plus4_d = pc + 4; rd1_d = r1; rd2_d = r2;
        imm_ext_d = imm; rs1_d = s1; rs2_d = s2; rd_d = d; ctrl_d = c; pc_src_e = ps;
    endtask

    // One clock: check combinational hazard outputs, predict next register state, compare after edge.
    task automatic step();
        logic lw;
        exp_t e;
        #1;
        lw = m.valid && (m.ctrl.result_src == RES_MEM) && (m.rd != 0) && valid_d
             && ((rs1_d == m.rd) || (rs2_d == m.rd));
        if (m_known) begin
            check("stall_f", stall_f, lw && !pc_src_e);
            check("stall_d", stall_d, lw && !pc_src_e);
            check("flush_d", flush_d, pc_src_e);
        end
        if (reset || pc_src_e || lw) begin
            m.valid = 0; m.ctrl = CTRL_NOP; m.pc = 0; m.pc4 = 0; m.rd1 = 0; m.rd2 = 0;
            m.imm = 0; m.rs1 = 0; m.rs2 = 0; m.rd = 0;
        end else begin
            m.valid = valid_d; m.ctrl = valid_d ? ctrl_d : CTRL_NOP; m.pc = pc_d;
            m.pc4 = pc_plus4_d; m.rd1 = rd1_d; m.rd2 = rd2_d; m.imm = imm_ext_d;
            m.rs1 = rs1_d; m.rs2 = rs2_d; m.rd = rd_d;
        end
        if (reset) begin
            m.bc = 0; m.fc = 0; m_known = 1'b1;
        end else if (pc_src_e) begin
            m.fc = sat(m.fc);
        end else if (lw) begin
            m.bc = sat(m.bc);
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("valid_e", valid_e, e.valid);
            check("ctrl_e", {22'd0, ctrl_e}, {22'd0, e.ctrl});
            check("pc_e", pc_e, e.pc);
            check("pc_plus4_e", pc_plus4_e, e.pc4);
            check("rd1_e", rd1_e, e.rd1);
            check("rd2_e", rd2_e, e.rd2);
            check("imm_ext_e", imm_ext_e, e.imm);
            check("rs1_e", rs1_e, e.rs1);
            check("rs2_e", rs2_e, e.rs2);
            check("rd_e", rd_e, e.rd);
            check("bubble_count", bubble_count, e.bc);
            check("flush_count", flush_count, e.fc);
        end
    endtask

    initial begin
        m = '{valid: 0, ctrl: CTRL_NOP, pc: 0, pc4: 0, rd1: 0, rd2: 0, imm: 0,
              rs1: 0, rs2: 0, rd: 0, bc: 0, fc: 0};
        reset = 1'b1;
        drive(1, 32'h40, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, CT_ADD, 1'b0);
        step();
        step();
        reset = 1'b0;

        // Plain capture
        drive(1, 32'h100, 32'h1234_5678, 32'hAA, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd5, CT_ADD, 1'b0);
        step();

        // Load-use: lw x5 then add reading x5 (stall, bubble, then capture)
        drive(1, 32'h104, 32'h0, 32'h0, 32'h8, 5'd2, 5'd0, 5'd5, CT_LW, 1'b0);
        step();
        drive(1, 32'h108, 32'h77, 32'h88, 32'h0, 5'd5, 5'd3, 5'd6, CT_ADD, 1'b0);
        step();
        step();
        check("bubble_after_lu", bubble_count, 32'd1);

        // Load to x0 does not stall
        drive(1, 32'h10C, 32'h0, 32'h0, 32'h4, 5'd1, 5'd0, 5'd0, CT_LW, 1'b0);
        step();
        drive(1, 32'h110, 32'h5, 32'h6, 32'h0, 5'd0, 5'd0, 5'd7, CT_ADD, 1'b0);
        step();

        // Redirect flush, then redirect coinciding with a load-use hazard
        drive(1, 32'h114, 32'h9, 32'hA, 32'h0, 5'd1, 5'd2, 5'd8, CT_ADD, 1'b1);
        step();
        drive(1, 32'h118, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd7, CT_LW, 1'b0);
        step();
        drive(1, 32'h11C, 32'h1, 32'h2, 32'h0, 5'd7, 5'd7, 5'd9, CT_ADD, 1'b1);
        step();

        // Random traffic with small register indices to provoke hazards
        for (int i = 0; i < 60; i++) begin
            ctrl_t c;
            c = ctrl_t'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) c.result_src = RES_MEM;
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), c, 1'($urandom_range(0, 5) == 0));
            step();
        end

        // Reset mid-stall with counters at 7 bubbles and 3 flushes
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, CTRL_NOP, 1'b0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1, 32'h200, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd4, CT_LW, 1'b0);
            step();
            drive(1, 32'h204, 32'h3, 32'h4, 32'h0, 5'd4, 5'd1, 5'd6, CT_ADD, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h300, 32'h1, 32'h1, 32'h1, 5'd1, 5'd1, 5'd1, CT_ADD, 1'b1);
            step();
        end
        check("bubble_pre_reset", bubble_count, 32'd7);
        check("flush_pre_reset", flush_count, 32'd3);
        drive(1, 32'h400, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd4, CT_LW, 1'b0);
        step();
        reset = 1'b1;
        drive(1, 32'h404, 32'h3, 32'h4, 32'h0, 5'd4, 5'd4, 5'd6, CT_ADD, 1'b0);
        step();
        reset = 1'b0;

        // Saturation: preload both counters to all-ones, then bubble and flush
        force dut.bubble_count = 32'hFFFF_FFFF;
        force dut.flush_count  = 32'hFFFF_FFFF;
        m.bc = 32'hFFFF_FFFF;
        m.fc = 32'hFFFF_FFFF;
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, CTRL_NOP, 1'b0);
        step();
        release dut.bubble_count;
        release dut.flush_count;
        drive(1, 32'h500, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd9, CT_LW, 1'b0);
        step();
        drive(1, 32'h504, 32'h1, 32'h2, 32'h0, 5'd3, 5'd9, 5'd10, CT_ADD, 1'b0);
        step();
        step();
        drive(1, 32'h508, 32'h1, 32'h2, 32'h0, 5'd3, 5'd3, 5'd10, CT_ADD, 1'b1);
        step();
        check("bubble_saturated", bubble_count, 32'hFFFF_FFFF);
        check("flush_saturated", flush_count, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute boundary of the pipelined RV32I core: captures the two register-file read operands (already write-bypassed by the register file), the immediate, PC values, register indices and the control bundle into the ID/EX pipeline register. Also detects load-use hazards, inserts bubbles, applies branch/jump flushes, and keeps saturating bubble/flush performance counters. Upstream is the decoder plus register file; downstream is the EX stage (ALU, forwarding muxes, branch resolution).

## Interface
- No parameters; data width fixed at 32, register index width 5.
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- valid_d  in  1  ID holds a real instruction
- pc_d, pc_plus4_d  in  32 each  PC and PC+4 of the ID instruction
- rd1_d, rd2_d  in  32 each  register-file read data for rs1/rs2
- imm_ext_d  in  32  sign-extended immediate
- rs1_d, rs2_d, rd_d  in  5 each  source/destination indices
- ctrl_d  in  ctrl_t  decoded control bundle (reg_write, result_src[1:0], mem_write, jump, branch, alu_ctrl[2:0], alu_src)
- pc_src_e  in  1  EX resolved a taken branch or a jump this cycle
- valid_e, pc_e, pc_plus4_e, rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e, ctrl_e  out  as above  registered ID/EX contents
- stall_f, stall_d  out  1 each  hold PC and IF/ID register
- flush_d  out  1  clear IF/ID register
- bubble_count, flush_count  out  32 each  performance counters

## Operation
- Load-use: lw_stall = valid_e & (ctrl_e.result_src == RES_MEM) & (rd_e != 0) & valid_d & ((rs1_d == rd_e) | (rs2_d == rd_e)).
- Register update priority on each rising edge: reset > pc_src_e > lw_stall > capture.
  - reset: valid_e=0, every field of ctrl_e=0, all data/index outputs=0, both counters=0.
  - pc_src_e=1: bubble; load valid_e=0, ctrl_e=0, data/index fields=0; flush_count += 1.
  - lw_stall=1 (and pc_src_e=0): same bubble; bubble_count += 1.
  - otherwise: capture all *_d inputs; valid_e=valid_d; if valid_d=0, ctrl_e is forced to 0.
- Bubble means no architectural side effect: reg_write, mem_write, branch and jump are all 0.
- stall_f = stall_d = lw_stall & ~pc_src_e; flush_d = pc_src_e. When both are raised, the redirect wins and neither stall is asserted.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- No WB-to-ID forwarding here: the register file already returns same-cycle write data.

## Timing
- Capture latency: 1 cycle, ID inputs at edge N appear on *_e after edge N.
- stall_f, stall_d, flush_d: combinational from current *_d inputs, ID/EX register state and pc_src_e, valid in the same cycle. No registered delay.
- A load-use stall lasts exactly one cycle. On the next edge a bubble occupies EX, so lw_stall drops and the held ID instruction is captured.
- Reset asserted mid-stall or mid-flush: the next edge yields the reset state, whatever the other inputs are. Stall outputs are 0 while the register holds its reset state (valid_e=0).
- Counter updates are visible 1 cycle after the qualifying cycle.

## Structure
- riscv_pkg (shared package):
  - ctrl_t packed struct.
  - result_src encodings: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10.
  - alu_ctrl constants.
  - CTRL_NOP (all zero).
- Sub-module hazard_detect: purely combinational. Computes lw_stall, stall_f, stall_d and flush_d. Instantiated once inside id_ex_stage.
- The pipeline register and counters live in id_ex_stage.

## Test plan
- Plain capture: valid_d=1, rd1_d=32'h1234_5678, imm_ext_d=32'hFFFF_FFF0, rd_d=5 -> next cycle valid_e=1, rd1_e=32'h1234_5678, imm_ext_e=32'hFFFF_FFF0, rd_e=5, stalls 0.
- Load-use: lw x5 in EX, add with rs1_d=5 in ID -> stall_f=stall_d=1 for one cycle, then valid_e=0 and ctrl_e=0, then the add is captured; bubble_count=1.
- Load to x0: lw x0 in EX, rs2_d=0 in ID -> no stall, bubble_count unchanged.
- Flush: pc_src_e=1 while valid_d=1 -> flush_d=1, next cycle valid_e=0 and ctrl_e.reg_write=0; flush_count=1. With lw_stall also forced true the same cycle -> stall_f=0 and flush wins.
- Reset mid-operation: reset=1 during a stall with counters at 7 and 3 -> next cycle all outputs 0 and counters 0.
- Saturation: preload bubble_count to 32'hFFFF_FFFF, trigger a load-use -> value stays 32'hFFFF_FFFF.
